slc3_control_unit: RTL and testbench

Instruction-sequencing FSM for the SLC-3 CPU. It sits directly upstream of the datapath.
- Consumes the opcode and IR bits plus BEN from the datapath.
- Drives every LD_*, Gate*, mux select, ALUK and MIO_EN control the datapath uses.
- Drives the active-low SRAM control strobes.
- Implements fetch, decode and execute for ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PAUSE, with a parameterised fixed memory wait.

---
 rtl/slc3_ctrl_pkg.sv | 82 ++++++++
 rtl/slc3_ctrl_if.sv | 34 +++
 rtl/mem_wait_counter.sv | 27 ++
 rtl/slc3_control_unit.sv | 187 ++++++++++++++++++
 tb/tb_slc3_control_unit.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slc3_ctrl_pkg.sv
// Shared types for the SLC-3 control unit: FSM states, opcodes, mux/ALU encodings
// and the bundled control word produced each cycle.
package slc3_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_HALTED, ST_S18, ST_S33, ST_S35, ST_S32,
    ST_S01, ST_S05, ST_S09, ST_S00, ST_S22,
    ST_S12, ST_S04, ST_S21, ST_S06, ST_S25,
    ST_S27, ST_S07, ST_S23, ST_S16, ST_P1, ST_P2
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  typedef enum logic [1:0] {
    PCMUX_INC  = 2'd0,
    PCMUX_BUS  = 2'd1,
    PCMUX_ADDR = 2'd2
  } pcmux_t;

  typedef enum logic [1:0] {
    ADDR2_ZERO  = 2'd0,
    ADDR2_OFF6  = 2'd1,
    ADDR2_OFF9  = 2'd2,
    ADDR2_OFF11 = 2'd3
  } addr2mux_t;

  typedef enum logic [1:0] {
    ALUK_ADD   = 2'd0,
    ALUK_AND   = 2'd1,
    ALUK_NOT   = 2'd2,
    ALUK_PASSA = 2'd3
  } aluk_t;

  typedef struct packed {
    logic      ld_mar;
    logic      ld_mdr;
    logic      ld_ir;
    logic      ld_ben;
    logic      ld_cc;
    logic      ld_reg;
    logic      ld_pc;
    logic      ld_led;
    logic      gate_pc;
    logic      gate_mdr;
    logic      gate_alu;
    logic      gate_marmux;
    pcmux_t    pcmux;
    addr2mux_t addr2mux;
    aluk_t     aluk;
    logic      drmux;
    logic      sr1mux;
    logic      sr2mux;
    logic      addr1mux;
    logic      mio_en;
    logic      mem_ce;
    logic      mem_ub;
    logic      mem_lb;
    logic      mem_oe;
    logic      mem_we;
  } ctrl_t;

  // Quiescent control word: nothing loads or drives, SRAM strobes deasserted (high).
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c        = '0;
    c.mem_ce = 1'b1;
    c.mem_ub = 1'b1;
    c.mem_lb = 1'b1;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/slc3_ctrl_if.sv
// Datapath-facing bundle of the SLC-3 control unit: instruction fields in,
// register loads, bus gates, mux selects and SRAM strobes out.
interface slc3_ctrl_if;
  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;
  logic       IR_5;
  logic       IR_11;
  logic       BEN;

  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX;
  logic [1:0] ADDR2MUX;
  logic [1:0] ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
  logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/mem_wait_counter.sv
// Counts the cycles an SRAM access has been held; done marks the final cycle
// of a MEM_WAIT-cycle access.
module mem_wait_counter #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

  logic [2:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 3'd1;
    end
  end

  assign done = enable && (count == LAST);

endmodule

// File: rtl/slc3_control_unit.sv
// SLC-3 instruction sequencer: fetch, decode and execute FSM with Moore outputs
// decoded from the current state and the memory wait counter.
module slc3_control_unit
  import slc3_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset_ah,
  slc3_ctrl_if.master bus
);

  state_t state, state_next;
  ctrl_t  c;
  logic   in_mem, wait_clear, wait_done;

  // The counter idles at zero outside the access states, so every access starts fresh.
  assign in_mem     = (state == ST_S33) || (state == ST_S25) || (state == ST_S16);
  assign wait_clear = !in_mem;

  mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk    (Clk),
    .reset  (Reset_ah),
    .clear  (wait_clear),
    .enable (in_mem),
    .done   (wait_done)
  );

  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      state <= ST_HALTED;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    c          = ctrl_idle();
    case (state)
      ST_HALTED: if (bus.Run) state_next = ST_S18;
      ST_S18: begin
        c.gate_pc  = 1'b1;
        c.ld_mar   = 1'b1;
        c.ld_pc    = 1'b1;
        c.pcmux    = PCMUX_INC;
        state_next = ST_S33;
      end
      ST_S33, ST_S25: begin
        c.mem_ce = 1'b0;
        c.mem_oe = 1'b0;
        c.mem_ub = 1'b0;
        c.mem_lb = 1'b0;
        c.mio_en = 1'b1;
        c.ld_mdr = wait_done;
        if (wait_done) begin
          if (state == ST_S33) state_next = ST_S35;
          else                 state_next = ST_S27;
        end
      end
      ST_S35: begin
        c.gate_mdr = 1'b1;
        c.ld_ir    = 1'b1;
        state_next = ST_S32;
      end
      ST_S32: begin
        c.ld_ben = 1'b1;
        case (bus.Opcode)
          OP_ADD:   state_next = ST_S01;
          OP_AND:   state_next = ST_S05;
          OP_NOT:   state_next = ST_S09;
          OP_BR:    state_next = ST_S00;
          OP_JMP:   state_next = ST_S12;
          OP_JSR:   state_next = ST_S04;
          OP_LDR:   state_next = ST_S06;
          OP_STR:   state_next = ST_S07;
          OP_PAUSE: state_next = ST_P1;
          default:  state_next = ST_S18;
        endcase
      end
      ST_S01, ST_S05, ST_S09: begin
        c.sr1mux   = 1'b1;
        c.gate_alu = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
        if (state == ST_S09) begin
          c.aluk = ALUK_NOT;
        end else begin
          c.sr2mux = bus.IR_5;
          if (state == ST_S05) c.aluk = ALUK_AND;
          else                 c.aluk = ALUK_ADD;
        end
        state_next = ST_S18;
      end
      ST_S00: state_next = bus.BEN ? ST_S22 : ST_S18;
      ST_S22, ST_S21: begin
        c.addr1mux = 1'b0;
        c.addr2mux = (state == ST_S22) ? ADDR2_OFF9 : ADDR2_OFF11;
        c.pcmux    = PCMUX_ADDR;
        c.ld_pc    = 1'b1;
        state_next = ST_S18;
      end
      ST_S12: begin
        c.sr1mux   = 1'b1;
        c.aluk     = ALUK_PASSA;
        c.gate_alu = 1'b1;
        c.pcmux    = PCMUX_BUS;
        c.ld_pc    = 1'b1;
        state_next = ST_S18;
      end
      // Only JSR (IR_11=1) is implemented; JSRR falls through as a no-op.
      ST_S04: begin
        if (bus.IR_11) begin
          c.gate_pc  = 1'b1;
          c.drmux    = 1'b1;
          c.ld_reg   = 1'b1;
          state_next = ST_S21;
        end else begin
          state_next = ST_S18;
        end
      end
      ST_S06, ST_S07: begin
        c.sr1mux      = 1'b1;
        c.addr1mux    = 1'b1;
        c.addr2mux    = ADDR2_OFF6;
        c.gate_marmux = 1'b1;
        c.ld_mar      = 1'b1;
        if (state == ST_S06) state_next = ST_S25;
        else                 state_next = ST_S23;
      end
      ST_S27: begin
        c.gate_mdr = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
        state_next = ST_S18;
      end
      ST_S23: begin
        c.sr1mux   = 1'b0;
        c.aluk     = ALUK_PASSA;
        c.gate_alu = 1'b1;
        c.ld_mdr   = 1'b1;
        c.mio_en   = 1'b0;
        state_next = ST_S16;
      end
      ST_S16: begin
        c.mem_ce = 1'b0;
        c.mem_we = 1'b0;
        c.mem_ub = 1'b0;
        c.mem_lb = 1'b0;
        if (wait_done) state_next = ST_S18;
      end
      ST_P1: begin
        c.ld_led = 1'b1;
        if (bus.Continue) state_next = ST_P2;
      end
      ST_P2: if (!bus.Continue) state_next = ST_S18;
      default: state_next = ST_HALTED;
    endcase
  end

  assign bus.LD_MAR     = c.ld_mar;
  assign bus.LD_MDR     = c.ld_mdr;
  assign bus.LD_IR      = c.ld_ir;
  assign bus.LD_BEN     = c.ld_ben;
  assign bus.LD_CC      = c.ld_cc;
  assign bus.LD_REG     = c.ld_reg;
  assign bus.LD_PC      = c.ld_pc;
  assign bus.LD_LED     = c.ld_led;
  assign bus.GatePC     = c.gate_pc;
  assign bus.GateMDR    = c.gate_mdr;
  assign bus.GateALU    = c.gate_alu;
  assign bus.GateMARMUX = c.gate_marmux;
  assign bus.PCMUX      = c.pcmux;
  assign bus.ADDR2MUX   = c.addr2mux;
  assign bus.ALUK       = c.aluk;
  assign bus.DRMUX      = c.drmux;
  assign bus.SR1MUX     = c.sr1mux;
  assign bus.SR2MUX     = c.sr2mux;
  assign bus.ADDR1MUX   = c.addr1mux;
  assign bus.MIO_EN     = c.mio_en;
  assign bus.Mem_CE     = c.mem_ce;
  assign bus.Mem_UB     = c.mem_ub;
  assign bus.Mem_LB     = c.mem_lb;
  assign bus.Mem_OE     = c.mem_oe;
  assign bus.Mem_WE     = c.mem_we;

endmodule

// File: tb/tb_slc3_control_unit.sv
// Self-checking bench: two control units (MEM_WAIT=2 and 3) driven in parallel and
// compared against per-instruction control traces built from the ISA timing rules.
module tb_slc3_control_unit;
  import slc3_ctrl_pkg::*;

  typedef struct {
    logic [3:0] op;
    logic       ir5;
    logic       ir11;
    logic       ben;
    int         per2;
    int         per3;
    int         we3;
  } vec_t;

  logic  Clk = 1'b0;
  logic  Reset_ah = 1'b1;
  int    total = 0;
  int    bad = 0;
  ctrl_t act2, act3;
  ctrl_t tr_buf[0:63];
  ctrl_t exp2[0:63];
  ctrl_t exp3[0:63];
  int    tr_len;
  vec_t  tbl[11];

  always #5 Clk = ~Clk;

  slc3_ctrl_if bus2();
  slc3_ctrl_if bus3();

  slc3_control_unit #(.MEM_WAIT(2)) dut2 (.Clk(Clk), .Reset_ah(Reset_ah), .bus(bus2));
  slc3_control_unit #(.MEM_WAIT(3)) dut3 (.Clk(Clk), .Reset_ah(Reset_ah), .bus(bus3));

  always_comb act2 = {bus2.LD_MAR, bus2.LD_MDR, bus2.LD_IR, bus2.LD_BEN, bus2.LD_CC,
                      bus2.LD_REG, bus2.LD_PC, bus2.LD_LED, bus2.GatePC, bus2.GateMDR,
                      bus2.GateALU, bus2.GateMARMUX, bus2.PCMUX, bus2.ADDR2MUX, bus2.ALUK,
                      bus2.DRMUX, bus2.SR1MUX, bus2.SR2MUX, bus2.ADDR1MUX, bus2.MIO_EN,
                      bus2.Mem_CE, bus2.Mem_UB, bus2.Mem_LB, bus2.Mem_OE, bus2.Mem_WE};
  always_comb act3 = {bus3.LD_MAR, bus3.LD_MDR, bus3.LD_IR, bus3.LD_BEN, bus3.LD_CC,
                      bus3.LD_REG, bus3.LD_PC, bus3.LD_LED, bus3.GatePC, bus3.GateMDR,
                      bus3.GateALU, bus3.GateMARMUX, bus3.PCMUX, bus3.ADDR2MUX, bus3.ALUK,
                      bus3.DRMUX, bus3.SR1MUX, bus3.SR2MUX, bus3.ADDR1MUX, bus3.MIO_EN,
                      bus3.Mem_CE, bus3.Mem_UB, bus3.Mem_LB, bus3.Mem_OE, bus3.Mem_WE};

  function automatic ctrl_t idle_ctrl();
    ctrl_t c;
    c = '0;
    c.mem_ce = 1'b1; c.mem_ub = 1'b1; c.mem_lb = 1'b1; c.mem_oe = 1'b1; c.mem_we = 1'b1;
    return c;
  endfunction

  // One cycle of a held SRAM access; a read latches MDR only on its final cycle.
  function automatic ctrl_t mem_cycle(bit write, bit last);
    ctrl_t c;
    c = idle_ctrl();
    c.mem_ce = 1'b0; c.mem_ub = 1'b0; c.mem_lb = 1'b0;
    if (write) begin
      c.mem_we = 1'b0;
    end else begin
      c.mem_oe = 1'b0;
      c.mio_en = 1'b1;
      c.ld_mdr = last;
    end
    return c;
  endfunction

  function automatic bit is_fetch_start(ctrl_t c);
    return c.gate_pc && c.ld_mar;
  endfunction

  function automatic void push(ctrl_t c);
    if (tr_len < 64) begin
      tr_buf[tr_len] = c;
      tr_len++;
    end
  endfunction

  // Expected per-cycle control trace of an instruction looping from the first fetch.
  task automatic build(input int mw, input logic [3:0] op, input logic ir5,
                       input logic ir11, input logic ben, input int n);
    ctrl_t c;
    tr_len = 0;
    while (tr_len < n) begin
      c = idle_ctrl(); c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; c.pcmux = PCMUX_INC; push(c);
      for (int i = 0; i < mw; i++) push(mem_cycle(0, i == mw - 1));
      c = idle_ctrl(); c.gate_mdr = 1; c.ld_ir = 1; push(c);
      c = idle_ctrl(); c.ld_ben = 1; push(c);
      c = idle_ctrl();
      case (op)
        4'b0001, 4'b0101, 4'b1001: begin
          c.sr1mux = 1; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
          if (op == 4'b0001) begin c.aluk = ALUK_ADD; c.sr2mux = ir5; end
          else if (op == 4'b0101) begin c.aluk = ALUK_AND; c.sr2mux = ir5; end
          else c.aluk = ALUK_NOT;
          push(c);
        end
        4'b0000: begin
          push(c);
          if (ben) begin
            c.addr2mux = ADDR2_OFF9; c.pcmux = PCMUX_ADDR; c.ld_pc = 1; push(c);
          end
        end
        4'b1100: begin
          c.sr1mux = 1; c.aluk = ALUK_PASSA; c.gate_alu = 1; c.pcmux = PCMUX_BUS; c.ld_pc = 1;
          push(c);
        end
        4'b0100: begin
          if (ir11) begin
            c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; push(c);
            c = idle_ctrl(); c.addr2mux = ADDR2_OFF11; c.pcmux = PCMUX_ADDR; c.ld_pc = 1; push(c);
          end else begin
            push(c);
          end
        end
        4'b0110, 4'b0111: begin
          c.sr1mux = 1; c.addr1mux = 1; c.addr2mux = ADDR2_OFF6; c.gate_marmux = 1; c.ld_mar = 1;
          push(c);
          if (op == 4'b0110) begin
            for (int i = 0; i < mw; i++) push(mem_cycle(0, i == mw - 1));
            c = idle_ctrl(); c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; push(c);
          end else begin
            c = idle_ctrl(); c.aluk = ALUK_PASSA; c.gate_alu = 1; c.ld_mdr = 1; push(c);
            for (int i = 0; i < mw; i++) push(mem_cycle(1, 0));
          end
        end
        4'b1101: begin
          c.ld_led = 1;
          while (tr_len < n) push(c);
        end
        default: ;
      endcase
    end
  endtask

  task automatic checkOutput(input string name, input ctrl_t act, input ctrl_t exp);
    logic [27:0] a, e;
    a = act;
    e = exp;
    total++;
    if (a !== e) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic ir5, input logic ir11,
                               input logic ben, input logic cont);
    bus2.Opcode = op; bus2.IR_5 = ir5; bus2.IR_11 = ir11; bus2.BEN = ben; bus2.Continue = cont;
    bus3.Opcode = op; bus3.IR_5 = ir5; bus3.IR_11 = ir11; bus3.BEN = ben; bus3.Continue = cont;
  endtask

  task automatic setRun(input logic v);
    bus2.Run = v;
    bus3.Run = v;
  endtask

  task automatic doReset();
    @(negedge Clk);
    Reset_ah = 1'b1;
    setRun(1'b0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_ah = 1'b0;
  endtask

  // Pulse Run (or leave it high to show it is ignored); returns on the first S18 sample.
  task automatic startRun(input bit hold);
    setRun(1'b1);
    @(posedge Clk);
    #1;
    if (!hold) setRun(1'b0);
    @(negedge Clk);
  endtask

  task automatic runTrace(input logic [3:0] op, input logic ir5, input logic ir11,
                          input logic ben, input int n, input bit hold, input string tag);
    build(2, op, ir5, ir11, ben, n);
    exp2 = tr_buf;
    build(3, op, ir5, ir11, ben, n);
    exp3 = tr_buf;
    applyStimulus(op, ir5, ir11, ben, 1'b0);
    doReset();
    checkOutput({tag, " halted mw2"}, act2, idle_ctrl());
    checkOutput({tag, " halted mw3"}, act3, idle_ctrl());
    startRun(hold);
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("%s c%0d mw2", tag, k), act2, exp2[k]);
      checkOutput($sformatf("%s c%0d mw3", tag, k), act3, exp3[k]);
      @(negedge Clk);
    end
    setRun(1'b0);
  endtask

  task automatic measureVec(input vec_t v, input string tag);
    int p2, p3, w3;
    applyStimulus(v.op, v.ir5, v.ir11, v.ben, 1'b0);
    doReset();
    startRun(1'b0);
    checkInt({tag, " fetch start"}, int'(is_fetch_start(act2) && is_fetch_start(act3)), 1);
    p2 = -1; p3 = -1; w3 = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge Clk);
      if (p2 < 0 && is_fetch_start(act2)) p2 = k;
      if (p3 < 0 && !act3.mem_we) w3++;
      if (p3 < 0 && is_fetch_start(act3)) p3 = k;
    end
    checkInt({tag, " period mw2"}, p2, v.per2);
    checkInt({tag, " period mw3"}, p3, v.per3);
    checkInt({tag, " write cycles mw3"}, w3, v.we3);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [3:0] rop;
    ctrl_t      p1;
    bit         found;

    tbl[0]  = '{4'b0001, 1, 0, 0, 6, 7, 0};
    tbl[1]  = '{4'b0101, 0, 0, 0, 6, 7, 0};
    tbl[2]  = '{4'b1001, 0, 0, 0, 6, 7, 0};
    tbl[3]  = '{4'b0000, 0, 0, 0, 6, 7, 0};
    tbl[4]  = '{4'b0000, 0, 0, 1, 7, 8, 0};
    tbl[5]  = '{4'b1100, 0, 0, 0, 6, 7, 0};
    tbl[6]  = '{4'b0100, 0, 1, 0, 7, 8, 0};
    tbl[7]  = '{4'b0100, 0, 0, 0, 6, 7, 0};
    tbl[8]  = '{4'b0110, 0, 0, 0, 9, 11, 0};
    tbl[9]  = '{4'b0111, 0, 0, 0, 9, 11, 3};
    tbl[10] = '{4'b1010, 0, 0, 0, 5, 6, 0};

    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    setRun(1'b0);

    doReset();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("reset idle c%0d mw2", i), act2, idle_ctrl());
      checkOutput($sformatf("reset idle c%0d mw3", i), act3, idle_ctrl());
      @(negedge Clk);
    end

    runTrace(4'b0001, 1'b1, 1'b0, 1'b0, 16, 0, "add_imm");
    runTrace(4'b0000, 1'b0, 1'b0, 1'b0, 16, 0, "br_not_taken");
    runTrace(4'b0000, 1'b0, 1'b0, 1'b1, 16, 0, "br_taken");
    runTrace(4'b0110, 1'b0, 1'b0, 1'b0, 24, 0, "ldr");
    runTrace(4'b0111, 1'b0, 1'b0, 1'b0, 24, 1, "str_run_held");

    for (int i = 0; i < 11; i++) measureVec(tbl[i], $sformatf("vec%0d op%b", i, tbl[i].op));

    for (int t = 0; t < 20; t++) begin
      rop = 4'($urandom_range(0, 15));
      runTrace(rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 24, bit'($urandom_range(0, 1)),
               $sformatf("rnd%0d op%b", t, rop));
    end

    // PAUSE handshake: LED load held until Continue, one instruction per press.
    p1 = idle_ctrl();
    p1.ld_led = 1'b1;
    applyStimulus(4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
    doReset();
    startRun(1'b0);
    repeat (10) @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("pause p1 c%0d mw2", i), act2, p1);
      checkOutput($sformatf("pause p1 c%0d mw3", i), act3, p1);
      @(negedge Clk);
    end
    applyStimulus(4'b1101, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checkOutput($sformatf("pause p2 c%0d mw2", i), act2, idle_ctrl());
      checkOutput($sformatf("pause p2 c%0d mw3", i), act3, idle_ctrl());
    end
    applyStimulus(4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    checkInt("pause release mw2", int'(is_fetch_start(act2)), 1);
    checkInt("pause release mw3", int'(is_fetch_start(act3)), 1);

    // Reset landing mid-write must drop the strobes on the very next cycle.
    applyStimulus(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
    doReset();
    startRun(1'b0);
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge Clk);
      if (!act3.mem_we) found = 1;
    end
    checkInt("s16 reached mw3", int'(found), 1);
    @(negedge Clk);
    checkInt("s16 second cycle we mw3", int'(act3.mem_we), 0);
    Reset_ah = 1'b1;
    @(negedge Clk);
    checkOutput("s16 reset idle mw3", act3, idle_ctrl());
    checkOutput("s16 reset idle mw2", act2, idle_ctrl());
    @(negedge Clk);
    checkOutput("s16 reset hold mw3", act3, idle_ctrl());
    Reset_ah = 1'b0;
    @(negedge Clk);
    checkOutput("s16 post reset halted mw3", act3, idle_ctrl());
    startRun(1'b0);
    checkInt("restart fetch mw2", int'(is_fetch_start(act2)), 1);
    checkInt("restart fetch mw3", int'(is_fetch_start(act3)), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
